ga_sched: RTL and testbench
===========================

Name: ga_sched

Overview:
- Generation scheduler for the GA datapath (pop_init → fitness → selection → crossover → mutation → buffer).
- Sequences the stage enables through pipeline fill, the initial generation (chromosomes sourced from the RNG) and steady-state generations (sourced from the buffer).
- Counts evaluated pairs and generations, tracks the best chromosome and its fitness, and stops on a generation limit or target fitness.

Parameters:
- POP_SIZE, 16: population size; must be even, ≥4. PAIRS = POP_SIZE/2.
- CHROM_W, 8: chromosome width.
- FIT_W, 27: signed fitness width.
- MAX_GEN, 64: number of generations run before termination.
- FILL_LAT, 3: cycles from ff_enable to the first valid crossover output.
- STALL_GENS, 8: used only with STALL_DETECT_EN.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse, begins a run
- target_fit  in  FIT_W  signed early-stop threshold
- fit_valid  in  1  fit1/fit2/chrom1/chrom2 hold one evaluated pair this cycle
- fit1, fit2  in  FIT_W  signed fitness of the pair
- chrom1, chrom2  in  CHROM_W  chromosomes of the pair
- ff_enable, sel_enable, xover_enable  out  1  stage enables
- buf_wenable, buf_renable  out  1  buffer write/read enables
- src_sel  out  1  fitness input mux: 0 = RNG, 1 = buffer
- gen_count  out  $clog2(MAX_GEN+1)  completed generations
- best  out  CHROM_W  best chromosome so far
- best_fit  out  FIT_W  fitness of best
- busy, done  out  1  status

Behaviour:
- Reset (reset=0, async): state=IDLE. All enables 0, src_sel=0, gen_count=0, best=0, best_fit=most-negative FIT_W value, busy=0, done=0. Pair counter and fill counter cleared. Reset asserted mid-run aborts immediately, with no partial result kept.
- All state is registered. Outputs change one cycle after the causing event.
- IDLE: start=1 → FILL. Clear gen_count, best, best_fit. Set busy=1.
- FILL: fill counter runs 0..FILL_LAT-1.
  - Count 0: assert ff_enable.
  - Count 1: add sel_enable.
  - Count FILL_LAT-1: add xover_enable, then → INIT.
  - Enables, once asserted, stay high until FINISH.
- INIT: src_sel=0, buf_wenable=1, buf_renable=0. Each fit_valid increments the pair counter.
  - When the counter = PAIRS-1 and fit_valid: counter→0, gen_count+1, → STEADY.
- STEADY: src_sel=1, buf_wenable=1, buf_renable=1. Same pair/generation counting as INIT.
- Termination, checked on the fit_valid cycle that ends a generation:
  - gen_count+1 = MAX_GEN → FINISH.
  - Independently, any fit_valid cycle where the updated best_fit ≥ target_fit (signed) → FINISH on the next edge; gen_count is not incremented unless that cycle also ended a generation.
- FINISH: all enables 0, busy=0, done=1. best and best_fit frozen. start=1 → FILL (new run; done cleared). start is ignored in FILL/INIT/STEADY.
- Best tracking, on every fit_valid in INIT/STEADY:
  - Candidate = fit1 ≥ fit2 ? (chrom1, fit1) : (chrom2, fit2); a tie goes to chrom1.
  - Replace best only if candidate fit > best_fit (strict; ties keep the incumbent).
  - Signed comparison throughout.
- fit_valid outside INIT/STEADY is ignored.
- gen_count saturates at MAX_GEN.

Optional Feature:
- Macro GA_SCHED_STALL_DETECT_EN.
- Defined: a stall counter resets to 0 whenever best_fit strictly improves and increments at each generation end without improvement. When it reaches STALL_GENS → FINISH, with gen_count incremented for that generation.
- Undefined: no stall counter; termination only by MAX_GEN or target_fit.

Test Plan:
- Reset check: reset low for 3 cycles, then high → all enables 0, best=0, best_fit=-2^26, done=0. Assert reset during STEADY → next sample IDLE with outputs at reset values.
- Fill sequencing: start pulse at cycle T → ff_enable high at T+2, sel_enable at T+3, xover_enable at T+4 (FILL_LAT=3); buf_wenable high entering INIT; src_sel=0.
- Generation counting, POP_SIZE=16: 8 fit_valid pulses → gen_count=1, src_sel=1, buf_renable=1. With MAX_GEN=4 and target_fit=2^26-1, 32 pulses → done=1, gen_count=4, enables 0.
- Best tracking: pairs (fit 10/5, chrom 0x11/0x22), (7/7, 0x33/0x44), (10/12, 0x55/0x66) → best=0x11/10, unchanged, then best=0x66/12. Negative pair (-3/-9) as the first pair → best_fit=-3.
- Target stop: target_fit=100; pair with fit2=100 at pair 3 → done next cycle, best_fit=100, gen_count=0. Start pulse during STEADY → ignored.
- Stall (macro defined, STALL_GENS=2): constant fitness 5 on every pair → FINISH after generation 3 (first generation improves, then two stalled), gen_count=3.

Source files
------------

// File: rtl/ga_sched.sv
// ---------------------------------------------------------------------------
// ga_sched -- generation scheduler for the GA datapath
//   (pop_init -> fitness -> selection -> crossover -> mutation -> buffer)
//
// Walks the stage enables through pipeline fill, runs the initial generation
// with chromosomes taken from the RNG, then runs steady-state generations
// with chromosomes taken from the buffer. Counts evaluated pairs and
// generations, keeps the best chromosome seen so far, and stops when the
// generation limit or the target fitness is reached.
//
// Optional feature: define GA_SCHED_STALL_DETECT_EN to also stop after
// STALL_GENS consecutive generations with no improvement of best_fit.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   start          single-cycle pulse, begins a run (IDLE or FINISH only)
//   target_fit     signed early-stop fitness threshold
//   fit_valid      fit1/fit2/chrom1/chrom2 carry one evaluated pair
//   fit1, fit2     signed fitness of the pair
//   chrom1, chrom2 chromosomes of the pair
//   ff_enable, sel_enable, xover_enable   stage enables
//   buf_wenable, buf_renable              buffer write/read enables
//   src_sel        fitness input mux: 0 = RNG, 1 = buffer
//   gen_count      completed generations (saturates at MAX_GEN)
//   best, best_fit best chromosome so far and its fitness
//   busy, done     run status
// ---------------------------------------------------------------------------
module ga_sched #(
    parameter int POP_SIZE   = 16,
    parameter int CHROM_W    = 8,
    parameter int FIT_W      = 27,
    parameter int MAX_GEN    = 64,
    parameter int FILL_LAT   = 3,
    parameter int STALL_GENS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [FIT_W-1:0]      target_fit,
    input  logic                         fit_valid,
    input  logic signed [FIT_W-1:0]      fit1,
    input  logic signed [FIT_W-1:0]      fit2,
    input  logic        [CHROM_W-1:0]    chrom1,
    input  logic        [CHROM_W-1:0]    chrom2,
    output logic                         ff_enable,
    output logic                         sel_enable,
    output logic                         xover_enable,
    output logic                         buf_wenable,
    output logic                         buf_renable,
    output logic                         src_sel,
    output logic [$clog2(MAX_GEN+1)-1:0] gen_count,
    output logic        [CHROM_W-1:0]    best,
    output logic signed [FIT_W-1:0]      best_fit,
    output logic                         busy,
    output logic                         done
);

    localparam int PAIRS = POP_SIZE / 2;
    localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int GW    = $clog2(MAX_GEN + 1);
    localparam int FCW   = (FILL_LAT > 1) ? $clog2(FILL_LAT) : 1;
    localparam int SW    = $clog2(STALL_GENS + 1);

    localparam logic [PW-1:0]  PAIR_LAST = PW'(PAIRS - 1);
    localparam logic [GW-1:0]  GEN_LAST  = GW'(MAX_GEN - 1);
    localparam logic [GW-1:0]  GEN_MAX   = GW'(MAX_GEN);
    localparam logic [FCW-1:0] FILL_LAST = FCW'(FILL_LAT - 1);
    localparam logic signed [FIT_W-1:0] FIT_MIN = {1'b1, {(FIT_W-1){1'b0}}};

    // Reject parameter sets the counters cannot represent.
    if ((POP_SIZE % 2 != 0) || (POP_SIZE < 4) || (FILL_LAT < 1) ||
        (MAX_GEN < 1) || (STALL_GENS < 1) || (SW < 1)) begin : g_param_err
        $error("ga_sched: illegal parameter set");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_INIT   = 3'd2,
        ST_STEADY = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [FCW-1:0]            fill_q, fill_d;
    logic [PW-1:0]             pair_q, pair_d;
    logic [GW-1:0]             gen_q, gen_d;
    logic [CHROM_W-1:0]        best_q, best_d;
    logic signed [FIT_W-1:0]   best_fit_q, best_fit_d;
    logic                      ff_q, ff_d, sel_q, sel_d, xover_q, xover_d;
    logic                      bufw_q, bufw_d, bufr_q, bufr_d, src_q, src_d;
    logic                      busy_q, busy_d, done_q, done_d;

    logic signed [FIT_W-1:0]   cand_fit_s;
    logic [CHROM_W-1:0]        cand_chrom_s;
    logic                      improve_s;
    logic                      gen_end_s;
    logic                      stop_s;

`ifdef GA_SCHED_STALL_DETECT_EN
    logic [SW-1:0]             stall_q, stall_d;
    logic                      improved_q, improved_d;
    logic                      improved_any_s;
`endif

    // Winner of the incoming pair; a tie goes to chrom1.
    always_comb begin
        if (fit1 >= fit2) begin
            cand_fit_s   = fit1;
            cand_chrom_s = chrom1;
        end else begin
            cand_fit_s   = fit2;
            cand_chrom_s = chrom2;
        end
    end

    // Next-state and next-output computation for the scheduler.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        pair_d     = pair_q;
        gen_d      = gen_q;
        best_d     = best_q;
        best_fit_d = best_fit_q;
        ff_d       = ff_q;
        sel_d      = sel_q;
        xover_d    = xover_q;
        bufw_d     = bufw_q;
        bufr_d     = bufr_q;
        src_d      = src_q;
        busy_d     = busy_q;
        done_d     = done_q;
        improve_s  = 1'b0;
        gen_end_s  = 1'b0;
        stop_s     = 1'b0;
`ifdef GA_SCHED_STALL_DETECT_EN
        stall_d        = stall_q;
        improved_d     = improved_q;
        improved_any_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    state_d    = ST_FILL;
                    fill_d     = {FCW{1'b0}};
                    pair_d     = {PW{1'b0}};
                    gen_d      = {GW{1'b0}};
                    best_d     = {CHROM_W{1'b0}};
                    best_fit_d = FIT_MIN;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
`ifdef GA_SCHED_STALL_DETECT_EN
                    stall_d    = {SW{1'b0}};
                    improved_d = 1'b0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_FILL: begin
                fill_d = fill_q + FCW'(1);
                if (fill_q == FCW'(0)) begin
                    ff_d = 1'b1;
                end else begin
                    ff_d = ff_q;
                end
                if (fill_q == FCW'(1)) begin
                    sel_d = 1'b1;
                end else begin
                    sel_d = sel_q;
                end
                // Last fill cycle: crossover output becomes valid, start INIT.
                if (fill_q == FILL_LAST) begin
                    xover_d = 1'b1;
                    bufw_d  = 1'b1;
                    bufr_d  = 1'b0;
                    src_d   = 1'b0;
                    fill_d  = {FCW{1'b0}};
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_INIT, ST_STEADY: begin
                if (fit_valid) begin
                    if (cand_fit_s > best_fit_q) begin
                        improve_s  = 1'b1;
                        best_d     = cand_chrom_s;
                        best_fit_d = cand_fit_s;
                    end else begin
                        improve_s  = 1'b0;
                    end
                    if (pair_q == PAIR_LAST) begin
                        gen_end_s = 1'b1;
                        pair_d    = {PW{1'b0}};
                        gen_d     = (gen_q == GEN_MAX) ? gen_q : gen_q + GW'(1);
                        state_d   = ST_STEADY;
                        src_d     = 1'b1;
                        bufr_d    = 1'b1;
                    end else begin
                        pair_d    = pair_q + PW'(1);
                    end
                    // best_fit_d is the post-update value: a pair that just
                    // reached the target stops the run on this edge.
                    if ((gen_end_s && (gen_q == GEN_LAST)) || (best_fit_d >= target_fit)) begin
                        stop_s = 1'b1;
                    end else begin
                        stop_s = 1'b0;
                    end
`ifdef GA_SCHED_STALL_DETECT_EN
                    // Stall is judged per generation: any improvement within
                    // the generation clears the count at its end.
                    improved_any_s = improved_q | improve_s;
                    if (gen_end_s) begin
                        improved_d = 1'b0;
                        if (improved_any_s) begin
                            stall_d = {SW{1'b0}};
                        end else begin
                            stall_d = stall_q + SW'(1);
                            if (stall_q + SW'(1) == SW'(STALL_GENS)) begin
                                stop_s = 1'b1;
                            end else begin
                                stop_s = stop_s;
                            end
                        end
                    end else begin
                        improved_d = improved_any_s;
                    end
`endif
                    if (stop_s) begin
                        state_d = ST_FINISH;
                        ff_d    = 1'b0;
                        sel_d   = 1'b0;
                        xover_d = 1'b0;
                        bufw_d  = 1'b0;
                        bufr_d  = 1'b0;
                        src_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        busy_d  = busy_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any run in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            fill_q     <= {FCW{1'b0}};
            pair_q     <= {PW{1'b0}};
            gen_q      <= {GW{1'b0}};
            best_q     <= {CHROM_W{1'b0}};
            best_fit_q <= FIT_MIN;
            ff_q       <= 1'b0;
            sel_q      <= 1'b0;
            xover_q    <= 1'b0;
            bufw_q     <= 1'b0;
            bufr_q     <= 1'b0;
            src_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef GA_SCHED_STALL_DETECT_EN
            stall_q    <= {SW{1'b0}};
            improved_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            pair_q     <= pair_d;
            gen_q      <= gen_d;
            best_q     <= best_d;
            best_fit_q <= best_fit_d;
            ff_q       <= ff_d;
            sel_q      <= sel_d;
            xover_q    <= xover_d;
            bufw_q     <= bufw_d;
            bufr_q     <= bufr_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef GA_SCHED_STALL_DETECT_EN
            stall_q    <= stall_d;
            improved_q <= improved_d;
`endif
        end
    end

    assign ff_enable    = ff_q;
    assign sel_enable   = sel_q;
    assign xover_enable = xover_q;
    assign buf_wenable  = bufw_q;
    assign buf_renable  = bufr_q;
    assign src_sel      = src_q;
    assign gen_count    = gen_q;
    assign best         = best_q;
    assign best_fit     = best_fit_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_ga_sched.sv
// ---------------------------------------------------------------------------
// tb_ga_sched -- self-checking bench for ga_sched (POP_SIZE=16, MAX_GEN=4).
// A reference model computes the expected best/best_fit/gen_count/done for
// every pair driven; those expectations are queued and compared after the
// clock edge on which the DUT registers its response.
// ---------------------------------------------------------------------------
module tb_ga_sched;

    localparam int POP   = 16;
    localparam int CW    = 8;
    localparam int FW    = 27;
    localparam int MG    = 4;
    localparam int FL    = 3;
    localparam int PAIRS = POP / 2;
    localparam int GW    = $clog2(MG + 1);
    localparam longint FIT_MIN = -(64'sd1 <<< (FW - 1));

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic                 fit_valid = 1'b0;
    logic signed [FW-1:0] target_fit = '0;
    logic signed [FW-1:0] fit1 = '0;
    logic signed [FW-1:0] fit2 = '0;
    logic [CW-1:0]        chrom1 = '0;
    logic [CW-1:0]        chrom2 = '0;
    logic                 ff_enable, sel_enable, xover_enable;
    logic                 buf_wenable, buf_renable, src_sel;
    logic [GW-1:0]        gen_count;
    logic [CW-1:0]        best;
    logic signed [FW-1:0] best_fit;
    logic                 busy, done;

    ga_sched #(
        .POP_SIZE(POP), .CHROM_W(CW), .FIT_W(FW),
        .MAX_GEN(MG), .FILL_LAT(FL), .STALL_GENS(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .target_fit(target_fit),
        .fit_valid(fit_valid), .fit1(fit1), .fit2(fit2),
        .chrom1(chrom1), .chrom2(chrom2),
        .ff_enable(ff_enable), .sel_enable(sel_enable), .xover_enable(xover_enable),
        .buf_wenable(buf_wenable), .buf_renable(buf_renable), .src_sel(src_sel),
        .gen_count(gen_count), .best(best), .best_fit(best_fit),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        longint best;
        longint best_fit;
        longint gen;
        longint done;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state
    longint m_best, m_fit, m_gen;
    int     m_pair;
    bit     m_active, m_done;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_enables(input string tag, input longint ff, input longint sel,
                                 input longint xo, input longint bw, input longint br);
        check_val({tag, ".ff_enable"},    longint'(ff_enable),    ff);
        check_val({tag, ".sel_enable"},   longint'(sel_enable),   sel);
        check_val({tag, ".xover_enable"}, longint'(xover_enable), xo);
        check_val({tag, ".buf_wenable"},  longint'(buf_wenable),  bw);
        check_val({tag, ".buf_renable"},  longint'(buf_renable),  br);
    endtask

    task automatic check_reset_state(input string tag);
        check_enables(tag, 0, 0, 0, 0, 0);
        check_val({tag, ".src_sel"},  longint'(src_sel),   0);
        check_val({tag, ".gen"},      longint'(gen_count), 0);
        check_val({tag, ".best"},     longint'(best),      0);
        check_val({tag, ".best_fit"}, longint'(best_fit),  FIT_MIN);
        check_val({tag, ".busy"},     longint'(busy),      0);
        check_val({tag, ".done"},     longint'(done),      0);
    endtask

    // Start pulse followed by the fill sequence; ends with the DUT in INIT.
    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_best = 0; m_fit = FIT_MIN; m_gen = 0; m_pair = 0;
        m_active = 1'b1; m_done = 1'b0;
        check_val({tag, ".busy"},     longint'(busy),     1);
        check_val({tag, ".done"},     longint'(done),     0);
        check_val({tag, ".best_fit"}, longint'(best_fit), FIT_MIN);
        check_enables({tag, ".t1"}, 0, 0, 0, 0, 0);
        tick();
        check_enables({tag, ".t2"}, 1, 0, 0, 0, 0);
        tick();
        check_enables({tag, ".t3"}, 1, 1, 0, 0, 0);
        tick();
        check_enables({tag, ".t4"}, 1, 1, 1, 1, 0);
        check_val({tag, ".src_sel"}, longint'(src_sel), 0);
    endtask

    // Drive one evaluated pair, queue the model's expectation, compare after the edge.
    task automatic send_pair(input longint f1, input longint f2, input longint c1, input longint c2);
        exp_t   e;
        longint cf, cc;
        fit_valid = 1'b1;
        fit1   = FW'(f1);
        fit2   = FW'(f2);
        chrom1 = CW'(c1);
        chrom2 = CW'(c2);
        if (m_active) begin
            if (f1 >= f2) begin cf = f1; cc = c1; end
            else          begin cf = f2; cc = c2; end
            if (cf > m_fit) begin m_fit = cf; m_best = cc; end
            if (m_pair == PAIRS - 1) begin
                m_pair = 0;
                m_gen++;
                if (m_gen == MG) m_done = 1'b1;
            end else begin
                m_pair++;
            end
            if (m_fit >= longint'(target_fit)) m_done = 1'b1;
            if (m_done) m_active = 1'b0;
        end
        e.best = m_best; e.best_fit = m_fit; e.gen = m_gen; e.done = longint'(m_done);
        sb_q.push_back(e);
        tick();
        fit_valid = 1'b0;
        e = sb_q.pop_front();
        check_val("pair.best",     longint'(best),      e.best);
        check_val("pair.best_fit", longint'(best_fit),  e.best_fit);
        check_val("pair.gen",      longint'(gen_count), e.gen);
        check_val("pair.done",     longint'(done),      e.done);
    endtask

    initial begin
        // Reset held for three cycles
        reset = 1'b0;
        repeat (3) tick();
        check_reset_state("rst");
        reset = 1'b1;
        tick();
        check_reset_state("idle");

        // Run 1: best tracking, generation counting, MAX_GEN stop
        target_fit = {1'b0, {(FW-1){1'b1}}};
        do_start("fill1");
        send_pair(10, 5, 'h11, 'h22);
        check_val("bt.first", longint'(best), 'h11);
        send_pair(7, 7, 'h33, 'h44);
        check_val("bt.keep", longint'(best), 'h11);
        send_pair(10, 12, 'h55, 'h66);
        check_val("bt.swap", longint'(best), 'h66);
        for (int i = 0; i < 5; i++) send_pair(i, 12, 'h70 + i, 'h80 + i);
        check_val("gen1.gen",     longint'(gen_count),   1);
        check_val("gen1.src_sel", longint'(src_sel),     1);
        check_enables("gen1", 1, 1, 1, 1, 1);
        // start during STEADY is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("ign.busy", longint'(busy),      1);
        check_val("ign.gen",  longint'(gen_count), 1);
        check_val("ign.src",  longint'(src_sel),   1);
        for (int i = 0; i < 3 * PAIRS; i++)
            send_pair(longint'($urandom_range(0, 200)) - 100,
                      longint'($urandom_range(0, 200)) - 100,
                      longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)));
        check_val("maxgen.done", longint'(done),      1);
        check_val("maxgen.gen",  longint'(gen_count), MG);
        check_val("maxgen.busy", longint'(busy),      0);
        check_enables("maxgen", 0, 0, 0, 0, 0);
        // fit_valid in FINISH leaves the result frozen
        send_pair(1000, 0, 'hAA, 'hBB);

        // Run 2: negative first pair, target stop
        target_fit = 27'sd100;
        do_start("fill2");
        send_pair(-3, -9, 'h77, 'h88);
        check_val("neg.best_fit", longint'(best_fit), -3);
        send_pair(0, 50, 'h01, 'h02);
        send_pair(20, 20, 'h03, 'h04);
        send_pair(40, 100, 'h99, 'hBC);
        check_val("tgt.done",     longint'(done),      1);
        check_val("tgt.best_fit", longint'(best_fit),  100);
        check_val("tgt.best",     longint'(best),      'hBC);
        check_val("tgt.gen",      longint'(gen_count), 0);
        check_enables("tgt", 0, 0, 0, 0, 0);

        // Run 3: reset asserted during STEADY aborts the run
        target_fit = {1'b0, {(FW-1){1'b1}}};
        do_start("fill3");
        for (int i = 0; i < PAIRS + 2; i++) send_pair(i + 1, 3, 'h10 + i, 'h20 + i);
        check_val("r3.gen", longint'(gen_count), 1);
        check_val("r3.src", longint'(src_sel),   1);
        reset = 1'b0;
        #1;
        check_reset_state("abort");
        sb_q.delete();
        tick();
        reset = 1'b1;
        tick();
        check_reset_state("abort.idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
